// File: rtl/posit_mult_arb.sv
// Round-robin arbiter sharing one combinational posit<N,ES> multiplier between NREQ requesters.
// Two register stages: S1 holds the operands and S2 holds the tagged result.

module posit_dec #(
  parameter int N  = 16,
  parameter int ES = 3,
  parameter int SW = 10
) (
  input  logic [N-1:0]          x_i,
  output logic                  sign_o,
  output logic                  nar_o,
  output logic                  zero_o,
  output logic signed [SW-1:0]  scale_o,
  output logic [N-1-ES:0]       mant_o
);
  localparam int RW = $clog2(N) + 1;
  localparam int FW = N - 1 - ES;

  logic [N-1:0]          mag;
  logic [N-2:0]          shifted;
  logic [RW-1:0]         run;
  logic                  rbit, cont;
  logic signed [SW-1:0]  runs, k;

  always_comb begin
    sign_o = x_i[N-1];
    zero_o = (x_i == '0);
    mag    = sign_o ? -x_i : x_i;
    // Only NaR keeps its top bit set after negation.
    nar_o  = mag[N-1];
    rbit   = mag[N-2];
    run    = '0;
    cont   = 1'b1;
    for (int i = N-2; i >= 0; i--) begin
      if (cont && (mag[i] == rbit)) run = run + RW'(1);
      else cont = 1'b0;
    end
    shifted = mag[N-2:0] << (run + RW'(1));
    runs    = SW'(run);
    k       = rbit ? (runs - SW'(1)) : -runs;
    scale_o = (k <<< ES) + $signed(SW'(shifted[N-2 -: ES]));
    mant_o  = {1'b1, shifted[FW-1:0]};
  end
endmodule

module posit_mult #(
  parameter int N  = 16,
  parameter int ES = 3
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         start_i,
  output logic [N-1:0] out_o,
  output logic         inf_o,
  output logic         zero_o,
  output logic         done_o
);
  localparam int FW   = N - 1 - ES;
  localparam int MW   = FW + 1;
  localparam int PW   = 2 * MW;
  localparam int TW   = ES + PW - 1;
  localparam int VW   = N + TW;
  localparam int SW   = $clog2(N) + ES + 3;
  localparam int KMAX = N - 2;

  logic [1:0][N-1:0]  opnd;
  logic [1:0]         sgn, nar, zro;
  logic [1:0][SW-1:0] scl;
  logic [1:0][MW-1:0] mnt;

  assign opnd = {a_i, b_i};

  for (genvar g = 0; g < 2; g++) begin : g_dec
    posit_dec #(.N(N), .ES(ES), .SW(SW)) u_dec (
      .x_i    (opnd[g]),
      .sign_o (sgn[g]),
      .nar_o  (nar[g]),
      .zero_o (zro[g]),
      .scale_o(scl[g]),
      .mant_o (mnt[g])
    );
  end

  logic [PW-1:0]         prod;
  logic                  ovf;
  logic [PW-2:0]         frac;
  logic signed [SW-1:0]  scale, k;
  logic [SW-1:0]         tsh;
  logic [VW-1:0]         rgm, vec;
  logic [N-2:0]          body, body_r, mag;
  logic                  guard, sticky, rnd;

  always_comb begin
    prod  = PW'(mnt[1]) * PW'(mnt[0]);
    ovf   = prod[PW-1];
    frac  = ovf ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    scale = $signed(scl[1]) + $signed(scl[0]) + $signed(SW'(ovf));
    k     = scale >>> ES;
    // Lay out regime | exponent | fraction MSB-first, then round to N-1 bits (nearest-even).
    tsh   = k[SW-1] ? (SW'(1) - k) : (k + SW'(2));
    rgm   = k[SW-1] ? ({1'b1, {(VW-1){1'b0}}} >> (-k)) : ~({VW{1'b1}} >> (k + SW'(1)));
    vec   = rgm | ({scale[ES-1:0], frac, {N{1'b0}}} >> tsh);
    body   = vec[VW-1 -: N-1];
    guard  = vec[VW-N];
    sticky = |vec[VW-N-1:0];
    rnd    = guard & (sticky | body[0]);
    body_r = body + (N-1)'(rnd);
    if (k >= SW'(KMAX))       mag = '1;
    else if (k < -SW'(KMAX))  mag = (N-1)'(1);
    else                      mag = body_r;
    inf_o  = |nar;
    zero_o = ~inf_o & (|zro);
    if (inf_o)        out_o = {1'b1, {(N-1){1'b0}}};
    else if (zero_o)  out_o = '0;
    else if (^sgn)    out_o = -{1'b0, mag};
    else              out_o = {1'b0, mag};
  end

  assign done_o = start_i;
endmodule

module posit_mult_arb #(
  parameter int N    = 16,
  parameter int ES   = 3,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_out,
  output logic              rsp_inf,
  output logic              rsp_zero,
  output logic              busy,
  output logic [CNTW-1:0]   op_count
);
  typedef struct packed {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [IDW-1:0] id;
  } s1_t;

  typedef struct packed {
    logic [N-1:0]   out;
    logic           inf;
    logic           zero;
    logic [IDW-1:0] id;
  } s2_t;

  logic [NREQ-1:0][N-1:0] a_arr, b_arr;
  assign a_arr = req_a;
  assign b_arr = req_b;

  s1_t            s1_q;
  s2_t            s2_q;
  logic           s1_valid_q, s2_valid_q;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0] op_count_q;

  logic           adv1, adv2, accept, gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [N-1:0]   m_out;
  logic           m_inf, m_zero, m_done;

  assign adv2 = ~s2_valid_q | rsp_ready;
  assign adv1 = ~s1_valid_q | adv2;

  always_comb begin : arb
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
    // Gated by rst_n so nothing looks granted while the pipeline is held in reset.
    req_ready = '0;
    if (adv1 && gnt_found && rst_n) req_ready[gnt_idx] = 1'b1;
    rr_ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
  end

  assign accept = |(req_valid & req_ready);

  posit_mult #(.N(N), .ES(ES)) u_mult (
    .a_i    (s1_q.a),
    .b_i    (s1_q.b),
    .start_i(s1_valid_q),
    .out_o  (m_out),
    .inf_o  (m_inf),
    .zero_o (m_zero),
    .done_o (m_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      rr_ptr_q   <= '0;
      op_count_q <= '0;
    end else begin
      if (adv1) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_q     <= '{a: a_arr[gnt_idx], b: b_arr[gnt_idx], id: gnt_idx};
          rr_ptr_q <= rr_ptr_d;
        end
      end
      if (adv2) begin
        s2_valid_q <= m_done;
        if (m_done) s2_q <= '{out: m_out, inf: m_inf, zero: m_zero, id: s1_q.id};
      end
      if (s2_valid_q && rsp_ready) op_count_q <= op_count_q + CNTW'(1);
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_id    = s2_q.id;
  assign rsp_out   = s2_q.out;
  assign rsp_inf   = s2_q.inf;
  assign rsp_zero  = s2_q.zero;
  assign busy      = s1_valid_q | s2_valid_q;
  assign op_count  = op_count_q;
endmodule

// File: doc/posit_mult_arb.md
Name: posit_mult_arb

Overview:
- Shares one combinational posit_mult core (N=16, es=3 datapath) between NREQ requesters.
- Per-requester valid/ready request ports feed a round-robin arbiter and a 2-stage registered pipeline: operand register S1, then the multiplier, then result register S2.
- One response channel returns the result tagged with the originating requester ID.
- Sits between the posit processing units' issue logic and the shared multiplier.

Parameters:
- N, 16, posit width.
- ES, 3, exponent field width, passed to posit_mult es.
- NREQ, 4, number of requesters, 2..8.
- IDW, 2, requester ID width, equals ceil(log2(NREQ)).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  grant/accept, one bit per requester.
- req_a  in  NREQ*N  operand A; requester i occupies bits [i*N +: N].
- req_b  in  NREQ*N  operand B, same packing as req_a.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  requester index of the result.
- rsp_out  out  N  product posit.
- rsp_inf  out  1  posit_mult inf flag.
- rsp_zero  out  1  posit_mult zero flag.
- busy  out  1  high when S1 or S2 valid.
- op_count  out  CNTW  count of completed response handshakes.

Behaviour:
- Reset (async, rst_n=0):
  - s1_valid=0, s2_valid=0, rr_ptr=0, op_count=0.
  - rsp_valid=0, busy=0, req_ready=0; rsp_id/out/inf/zero=0.
  - Operand registers are cleared.
  - Reset mid-operation discards all in-flight ops; no response is issued for them.
- Advance conditions:
  - adv2 = ~s2_valid | rsp_ready.
  - adv1 = ~s1_valid | adv2.
- Arbitration (combinational):
  - If adv1=1, grant the first requester with req_valid=1, searching from index rr_ptr upward with wrap NREQ-1 -> 0.
  - req_ready has exactly one hot bit (the granted index), or is all zero if adv1=0 or no request is pending.
  - req_ready never depends on rsp_ready other than through adv2. No combinational path from req_valid to rsp_*.
- Accept (handshake req_valid[g] & req_ready[g] at edge):
  - S1 <= {req_a[g], req_b[g], g}; s1_valid <= 1.
  - rr_ptr <= (g+1) mod NREQ.
  - rr_ptr is unchanged on cycles with no accept.
- S1 -> S2:
  - If adv2 & s1_valid, S2 <= {posit_mult(S1.a, S1.b) out/inf/zero, S1.id}; s2_valid <= 1.
  - Else if adv2 & ~s1_valid, s2_valid <= 0.
  - If adv1 & no accept, s1_valid <= 0.
  - posit_mult start is tied to s1_valid; done is unused.
- Latency and throughput:
  - Accept at edge T -> rsp_valid=1 after edge T+1 (visible in cycle T+1..T+2, i.e. 2 edges from request acceptance to response visible at S2).
  - Throughput is one op per cycle with rsp_ready held high.
- Backpressure:
  - rsp_valid=1 & rsp_ready=0 freezes S2, and S1 if valid; all req_ready drop to 0.
  - rsp_* outputs are stable while stalled.
  - Simultaneous S2 drain and new accept in the same cycle is allowed; no bubble.
- Ordering: responses leave in acceptance order. Capacity is 2 ops in flight.
- Simultaneous requests: a requester holding valid is granted within NREQ accept opportunities (fairness).
- op_count increments on each rsp_valid & rsp_ready and wraps at 2^CNTW-1 -> 0.
- busy = s1_valid | s2_valid.

Test Plan:
1. Single op: req 0 issues a=0x4000 (1.0), b=0x4400 (2.0), rsp_ready=1 -> rsp_valid 2 edges after accept; rsp_out=0x4400, rsp_id=0, inf=0, op_count=1.
2. Sign/special values:
   - 0xC000 * 0x4400 -> rsp_out=0xBC00.
   - 0x4400 * 0x4400 -> 0x4800.
   - 0x8000 * 0x4000 -> rsp_out=0x8000, rsp_inf=1.
   - 0x0000 * 0x4000 -> rsp_out=0x0000.
3. Round-robin: all 4 requesters hold valid with distinct operands for 8 cycles, rr_ptr=0 -> grant order 0,1,2,3,0,1,2,3; rsp_id follows the same order; one response per cycle.
4. Backpressure: 2 ops in flight, rsp_ready=0 for 5 cycles -> req_ready=0, rsp_* stable. After release, both results emerge in order on consecutive cycles with no loss or duplication.
5. Reset mid-flight: rst_n pulsed low while s1_valid=s2_valid=1 -> all outputs 0 immediately (async); after release, no stale responses, rr_ptr=0, op_count=0.
6. Counter wrap: preload via 2^CNTW responses (CNTW=4 build: 16 ops) -> op_count returns to 0.
